stl_trans_buf: RTL and testbench
================================

STL_TRANS_BUF -- requirements
Module: stl_trans_buf

Interface
REQ-001 SHALL have parameter WX, default 4, number of rows per matrix (>=1).
REQ-002 SHALL have parameter WY, default 5, number of columns per matrix (>=1).
REQ-003 SHALL have parameter DW, default 8, element width in bits (>=1).
REQ-004 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous to clk_i, active-high.
REQ-006 SHALL have port in_vld_i  input  1  input row valid.
REQ-007 SHALL have port in_rdy_o  output  1  input row ready.
REQ-008 SHALL have port in_data_i  input  WY*DW  one row; element j at bits [j*DW +: DW].
REQ-009 SHALL have port out_vld_o  output  1  output column valid.
REQ-010 SHALL have port out_rdy_i  input  1  output column ready.
REQ-011 SHALL have port out_data_o  output  WX*DW  one column; element of row i at bits [i*DW +: DW].
REQ-012 SHALL have port out_last_o  output  1  high with column WY-1 of each matrix.

Function
REQ-013 SHALL accept a row when in_vld_i & in_rdy_o and a column when out_vld_o & out_rdy_i (transfer).
REQ-014 SHALL write the k-th accepted row of a matrix (k = 0..WX-1) into row k of the active write bank; row counter wraps to 0 after WX-1.
REQ-015 SHALL mark a bank full on the cycle after its WX-th row is accepted.
REQ-016 SHALL present, while out_vld_o, out_data_o element i = row i, element c of the read bank, where c (0..WY-1) is the column counter; c advances on each output transfer and wraps to 0 after WY-1.
REQ-017 SHALL mark the read bank empty, and swap read bank, on the output transfer with out_last_o high.
REQ-018 SHALL drive out_vld_o = read bank full and in_rdy_o = write bank not full, both purely from registered state (no combinational path from in_vld_i or out_rdy_i).
REQ-019 SHALL hold out_data_o and out_last_o stable while out_vld_o & !out_rdy_i.
REQ-020 SHALL drive out_data_o = 0 and out_last_o = 0 whenever out_vld_o = 0.
REQ-021 SHALL make the first column valid exactly 1 cycle after the last row of a matrix is accepted (if the read side is idle).
REQ-022 SHALL, when a bank's fill-complete and another bank's drain-complete occur in the same cycle, apply both updates in that cycle with no lost or duplicated data.
REQ-023 SHALL support WX=1 and/or WY=1 (counters of width max(1,$clog2(N))); WX=WY=1 degenerates to a registered 1-deep buffer.

Reset
REQ-024 SHALL, while rst_i high at a clock edge, clear row/column counters, bank full flags and bank pointers; after reset out_vld_o=0, out_last_o=0, out_data_o=0, in_rdy_o=1.
REQ-025 SHALL discard any partially filled or partially drained matrix on reset; storage contents are not reset.

Configuration
REQ-026 SHALL, when STL_TRANS_PINGPONG_EN is defined, implement two banks: writing fills one while the other drains, sustaining 1 row/cycle input when WY<=WX and out_rdy_i held high.
REQ-027 SHALL, when STL_TRANS_PINGPONG_EN is undefined, implement one bank as FSM FILL->DRAIN (after WX-th row accepted) ->FILL (after WY-th column accepted); in_rdy_o=0 throughout DRAIN, out_vld_o=0 throughout FILL.

Verification
REQ-028 SHALL cover basic transpose: WX=4,WY=5,DW=8, row i element j = 16*i+j, out_rdy_i=1 -> columns c=0..4 carry {0x30+c,0x20+c,0x10+c,0x00+c} (row 3 MSB), out_last_o only on c=4, first column 1 cycle after row 3.
REQ-029 SHALL cover backpressure: out_rdy_i toggled 1-0-0-1 during drain -> out_data_o/out_last_o unchanged during stalls, 5 columns total, none repeated or skipped.
REQ-030 SHALL cover reset mid-operation: rst_i pulsed after 2 rows accepted -> next cycle in_rdy_o=1, out_vld_o=0; following 4 rows form a complete new matrix output correctly.
REQ-031 SHALL cover ping-pong throughput (macro defined, WX=WY=4): 3 matrices streamed back-to-back, out_rdy_i=1 -> in_rdy_o never deasserts after first matrix, all 12 columns correct in order.
REQ-032 SHALL cover single-bank mode (macro undefined): 2 matrices offered continuously -> in_rdy_o=0 for exactly WY cycles of drain, second matrix correct.
REQ-033 SHALL cover degenerate WX=1,WY=3 -> each accepted row yields 3 single-element columns equal to elements 0,1,2, out_last_o on the third.

Source files
------------

// File: rtl/stl_trans_buf.sv
// stl_trans_buf: matrix transpose buffer. Rows of WY elements go in and
// columns of WX elements come out.
// Build option: define STL_TRANS_PINGPONG_EN for two banks, so one bank fills
// while the other drains. Without it, a single bank alternates between FILL
// and DRAIN.
module stl_trans_buf #(
    parameter int unsigned WX = 4,
    parameter int unsigned WY = 5,
    parameter int unsigned DW = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_vld_i,
    output logic             in_rdy_o,
    input  logic [WY*DW-1:0] in_data_i,
    output logic             out_vld_o,
    input  logic             out_rdy_i,
    output logic [WX*DW-1:0] out_data_o,
    output logic             out_last_o
);

    localparam int unsigned RW = (WX > 1) ? $clog2(WX) : 1;
    localparam int unsigned CW = (WY > 1) ? $clog2(WY) : 1;
`ifdef STL_TRANS_PINGPONG_EN
    localparam int unsigned NB = 2;
`else
    localparam int unsigned NB = 1;
`endif

    logic [DW-1:0] r_mem [NB][WX][WY];
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;

    logic w_in_xfer;
    logic w_out_xfer;
    logic w_fill_done;
    logic w_drain_done;
    logic w_wr_bank;
    logic w_rd_bank;
    logic w_wr_full;
    logic w_rd_full;

    assign w_in_xfer    = in_vld_i & in_rdy_o;
    assign w_out_xfer   = out_vld_o & out_rdy_i;
    assign w_fill_done  = w_in_xfer & (r_row == RW'(WX - 1));
    assign w_drain_done = w_out_xfer & (r_col == CW'(WY - 1));

    // Handshakes come only from registered bank state.
    assign in_rdy_o  = ~w_wr_full;
    assign out_vld_o = w_rd_full;

`ifdef STL_TRANS_PINGPONG_EN
    logic       r_wr_bank;
    logic       r_rd_bank;
    logic [1:0] r_full;

    // Bank flags and pointers. A fill and a drain of different banks can
    // complete in the same cycle, and both updates take effect together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_full    <= 2'b00;
        end else begin
            if (w_fill_done) begin
                r_full[r_wr_bank] <= 1'b1;
                r_wr_bank         <= ~r_wr_bank;
            end
            if (w_drain_done) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
            end
        end
    end

    assign w_wr_bank = r_wr_bank;
    assign w_rd_bank = r_rd_bank;
    assign w_wr_full = r_full[r_wr_bank];
    assign w_rd_full = r_full[r_rd_bank];
`else
    typedef enum logic [0:0] {StFill, StDrain} state_e;

    state_e r_state;
    state_e w_state_nxt;

    // State register for the single-bank FILL/DRAIN sequence.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StFill;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: go to DRAIN after the last row, and back to FILL after the last column.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StFill:  if (w_fill_done)  w_state_nxt = StDrain;
            StDrain: if (w_drain_done) w_state_nxt = StFill;
            default: w_state_nxt = StFill;
        endcase
    end

    assign w_wr_bank = 1'b0;
    assign w_rd_bank = 1'b0;
    assign w_wr_full = (r_state == StDrain);
    assign w_rd_full = (r_state == StDrain);
`endif

    // Row and column counters. Each one wraps at the end of its matrix.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_row <= '0;
            r_col <= '0;
        end else begin
            if (w_in_xfer) begin
                r_row <= w_fill_done ? '0 : r_row + RW'(1);
            end
            if (w_out_xfer) begin
                r_col <= w_drain_done ? '0 : r_col + CW'(1);
            end
        end
    end

    // Storage write. This array is not reset: stale data is never presented.
    always_ff @(posedge clk_i) begin
        if (w_in_xfer) begin
            for (int j = 0; j < int'(WY); j++) begin
                r_mem[w_wr_bank][r_row][j] <= in_data_i[j*DW +: DW];
            end
        end
    end

    // Column read mux. The output is zeroed while not valid.
    always_comb begin
        out_data_o = '0;
        out_last_o = 1'b0;
        if (w_rd_full) begin
            for (int i = 0; i < int'(WX); i++) begin
                out_data_o[i*DW +: DW] = r_mem[w_rd_bank][i][r_col];
            end
            out_last_o = (r_col == CW'(WY - 1));
        end
    end

endmodule

// File: tb/tb_stl_trans_buf.sv
// Self-checking bench for stl_trans_buf. It uses three instances:
// main 4x5, square 4x4 and degenerate 1x3.
module tb_stl_trans_buf;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Main instance: WX=4, WY=5
    logic        m_in_vld, m_in_rdy, m_out_vld, m_out_rdy, m_out_last;
    logic [39:0] m_in_data;
    logic [31:0] m_out_data;
    // Square instance: WX=WY=4
    logic        s_in_vld, s_in_rdy, s_out_vld, s_out_rdy, s_out_last;
    logic [31:0] s_in_data;
    logic [31:0] s_out_data;
    // Degenerate instance: WX=1, WY=3
    logic        d_in_vld, d_in_rdy, d_out_vld, d_out_rdy, d_out_last;
    logic [23:0] d_in_data;
    logic [7:0]  d_out_data;

    stl_trans_buf #(.WX(4), .WY(5), .DW(8)) u_main (
        .clk_i(clk), .rst_i(rst),
        .in_vld_i(m_in_vld), .in_rdy_o(m_in_rdy), .in_data_i(m_in_data),
        .out_vld_o(m_out_vld), .out_rdy_i(m_out_rdy), .out_data_o(m_out_data),
        .out_last_o(m_out_last)
    );

    stl_trans_buf #(.WX(4), .WY(4), .DW(8)) u_sq (
        .clk_i(clk), .rst_i(rst),
        .in_vld_i(s_in_vld), .in_rdy_o(s_in_rdy), .in_data_i(s_in_data),
        .out_vld_o(s_out_vld), .out_rdy_i(s_out_rdy), .out_data_o(s_out_data),
        .out_last_o(s_out_last)
    );

    stl_trans_buf #(.WX(1), .WY(3), .DW(8)) u_dg (
        .clk_i(clk), .rst_i(rst),
        .in_vld_i(d_in_vld), .in_rdy_o(d_in_rdy), .in_data_i(d_in_data),
        .out_vld_o(d_out_vld), .out_rdy_i(d_out_rdy), .out_data_o(d_out_data),
        .out_last_o(d_out_last)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Row i of a matrix: element j = base + 16*i + j
    function automatic logic [39:0] row5(input logic [7:0] base, input int i);
        logic [39:0] r;
        for (int j = 0; j < 5; j++) r[j*8 +: 8] = 8'(base + 16 * i + j);
        return r;
    endfunction

    function automatic logic [31:0] row4(input logic [7:0] base, input int i);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[j*8 +: 8] = 8'(base + 16 * i + j);
        return r;
    endfunction

    // Column c of a 4-row matrix: row i element = base + 16*i + c, with row 3 in the MSB
    function automatic logic [31:0] col4(input logic [7:0] base, input int c);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'(base + 16 * i + c);
        return r;
    endfunction

    task automatic send_m(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            m_in_vld  = 1'b1;
            m_in_data = row5(base, i);
            chk("m_in_rdy", m_in_rdy, 1);
            @(posedge clk);
        end
    endtask

    // Drain one matrix from the main instance. pat supplies out_rdy per cycle, LSB first.
    task automatic drain_m(input logic [7:0] base, input logic [7:0] pat, input string tag);
        int col = 0;
        int cyc = 0;
        while (col < 5 && cyc < 40) begin
            @(negedge clk);
            m_in_vld  = 1'b0;
            m_out_rdy = pat[cyc % 8];
            chk({tag, "_vld"}, m_out_vld, 1);
            chk({tag, "_data"}, m_out_data, col4(base, col));
            chk({tag, "_last"}, m_out_last, (col == 4));
            @(posedge clk);
            if (m_out_rdy) col++;
            cyc++;
        end
        chk({tag, "_ncol"}, col, 5);
        @(negedge clk);
        m_out_rdy = 1'b0;
        chk({tag, "_idle_vld"}, m_out_vld, 0);
        chk({tag, "_idle_data"}, m_out_data, 0);
        chk({tag, "_idle_last"}, m_out_last, 0);
        chk({tag, "_idle_rdy"}, m_in_rdy, 1);
    endtask

    initial begin
        logic [23:0] dg_row;
        rst = 1'b1;
        m_in_vld = 0; m_out_rdy = 0; m_in_data = '0;
        s_in_vld = 0; s_out_rdy = 0; s_in_data = '0;
        d_in_vld = 0; d_out_rdy = 0; d_in_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_m_rdy", m_in_rdy, 1);
        chk("rst_m_vld", m_out_vld, 0);
        chk("rst_m_data", m_out_data, 0);
        chk("rst_m_last", m_out_last, 0);
        chk("rst_s_rdy", s_in_rdy, 1);
        chk("rst_d_vld", d_out_vld, 0);

        // Basic transpose: the first column is checked at the first negedge after row 3
        send_m(8'h00, 4);
        drain_m(8'h00, 8'hFF, "basic");

        // Backpressure: out_rdy follows 1,0,0,1,1,1,...
        send_m(8'h80, 4);
        drain_m(8'h80, 8'b1111_1001, "bp");

        // Reset after two rows have been accepted
        send_m(8'h00, 2);
        @(negedge clk);
        m_in_vld = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_rdy", m_in_rdy, 1);
        chk("midrst_vld", m_out_vld, 0);
        send_m(8'h40, 4);
        drain_m(8'h40, 8'hFF, "midrst");

`ifdef STL_TRANS_PINGPONG_EN
        // Ping-pong: stream three 4x4 matrices back to back
        s_out_rdy = 1'b1;
        fork
            begin
                for (int r = 0; r < 12; r++) begin
                    @(negedge clk);
                    s_in_vld  = 1'b1;
                    s_in_data = row4(8'(64 * (r / 4)), r % 4);
                    chk("pp_in_rdy", s_in_rdy, 1);
                    @(posedge clk);
                end
                @(negedge clk);
                s_in_vld = 1'b0;
            end
            begin
                int k = 0;
                int cyc = 0;
                while (k < 12 && cyc < 80) begin
                    @(negedge clk);
                    if (s_out_vld) begin
                        chk("pp_data", s_out_data, col4(8'(64 * (k / 4)), k % 4));
                        chk("pp_last", s_out_last, (k % 4 == 3));
                        k++;
                    end
                    cyc++;
                end
                chk("pp_ncol", k, 12);
            end
        join
        s_out_rdy = 1'b0;
`else
        // Single bank: offer two matrices continuously. in_rdy stays low for exactly 5 cycles.
        m_out_rdy = 1'b1;
        fork
            begin
                int low = 0;
                for (int r = 0; r < 8; r++) begin
                    int guard = 0;
                    @(negedge clk);
                    m_in_vld  = 1'b1;
                    m_in_data = row5((r < 4) ? 8'h00 : 8'h80, r % 4);
                    while (!m_in_rdy && guard < 20) begin
                        low++;
                        guard++;
                        @(posedge clk);
                        @(negedge clk);
                    end
                    @(posedge clk);
                end
                @(negedge clk);
                m_in_vld = 1'b0;
                chk("sb_rdy_low", low, 5);
            end
            begin
                int k = 0;
                int cyc = 0;
                while (k < 10 && cyc < 80) begin
                    @(negedge clk);
                    if (m_out_vld) begin
                        chk("sb_data", m_out_data, col4((k < 5) ? 8'h00 : 8'h80, k % 5));
                        chk("sb_last", m_out_last, (k % 5 == 4));
                        k++;
                    end
                    cyc++;
                end
                chk("sb_ncol", k, 10);
            end
        join
        m_out_rdy = 1'b0;
`endif

        // Degenerate 1x3: each row comes out as three single-element columns
        for (int t = 0; t < 2; t++) begin
            dg_row = (t == 0) ? 24'h33_22_11 : 24'hA6_5C_04;
            @(negedge clk);
            d_in_vld  = 1'b1;
            d_in_data = dg_row;
            chk("dg_in_rdy", d_in_rdy, 1);
            @(posedge clk);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                d_in_vld  = 1'b0;
                d_out_rdy = 1'b1;
                chk("dg_vld", d_out_vld, 1);
                chk("dg_data", d_out_data, dg_row[c*8 +: 8]);
                chk("dg_last", d_out_last, (c == 2));
                @(posedge clk);
            end
            @(negedge clk);
            d_out_rdy = 1'b0;
            chk("dg_idle_vld", d_out_vld, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
